// File: rtl/mem_lane_pkg.sv
// Shared types and helpers for the load/store lane controller.
// funct3 encodings, FSM state type and access size decode.
package mem_lane_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Access size in bytes: 1, 2, 4 or 8.
   function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
      size_bytes = 4'd1 << funct3[1:0];
   endfunction

endpackage

// File: rtl/mem_lane_ctrl_be_gen.sv
// Byte-enable and lane-aligned write data generation.
// Produces a double-width mask/data pair so word-crossing accesses split cleanly.
module be_gen
   import mem_lane_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]                 funct3,
   input  logic [$clog2(XLEN/8)-1:0]  off,
   input  logic [XLEN-1:0]            wdata,
   output logic [2*(XLEN/8)-1:0]      mask2,
   output logic [2*XLEN-1:0]          wdata2
);

   localparam int BYTES = XLEN / 8;

   logic [BYTES-1:0] lanes;
   logic [XLEN-1:0]  wd;
   int               nb;

   // Size mask and size-trimmed data, then shift both to the byte offset.
   always_comb begin
      nb    = int'(size_bytes(funct3));
      lanes = '0;
      wd    = '0;
      for (int i = 0; i < BYTES; i++) begin
         lanes[i] = (i < nb);
         if (i < nb) wd[8*i +: 8] = wdata[8*i +: 8];
      end
      mask2  = {{BYTES{1'b0}}, lanes} << off;
      wdata2 = {{XLEN{1'b0}}, wd} << {off, 3'b000};
   end

endmodule

// File: rtl/mem_lane_ctrl.sv
// Load/store lane controller between the memory stage and data memory.
// Sequences one or two memory beats per access and extends load data.
module mem_lane_ctrl
   import mem_lane_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int MISALIGN_SPLIT = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [XLEN-1:0]       req_wdata,
   output logic                  mem_valid,
   input  logic                  mem_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [XLEN/8-1:0]     mem_be,
   output logic [XLEN-1:0]       mem_wdata,
   input  logic [XLEN-1:0]       mem_rdata,
   output logic                  rsp_valid,
   output logic [XLEN-1:0]       rsp_rdata,
   output logic                  rsp_fault
);

   localparam int BYTES = XLEN / 8;
   localparam int OFFW  = $clog2(BYTES);

   state_t                state, state_nx;
   logic                  we_q;
   logic [2:0]            f3_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [XLEN-1:0]       wdata_q;
   logic                  fault_q;
   logic [2*XLEN-1:0]     rbuf;

   logic [OFFW-1:0]       off_q;
   logic [2*BYTES-1:0]    mask2;
   logic [2*XLEN-1:0]     wdata2;
   logic                  split_q;
   logic [ADDR_WIDTH-1:0] base_q;

   logic                  accept;
   logic                  in_legal;
   logic                  in_cross;
   logic                  in_fault;

   logic [2*XLEN-1:0]     shifted;
   logic [XLEN-1:0]       load_res;
   logic                  sgn;
   int                    nb;
   int                    in_end;

   assign off_q   = addr_q[OFFW-1:0];
   assign base_q  = {addr_q[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
   assign split_q = |mask2[2*BYTES-1:BYTES];
   assign accept  = (state == IDLE) && req_valid;

   be_gen #(
      .XLEN (XLEN)
   ) u_be_gen (
      .funct3 (f3_q),
      .off    (off_q),
      .wdata  (wdata_q),
      .mask2  (mask2),
      .wdata2 (wdata2)
   );

   // Classify the incoming request: legal encoding and word crossing.
   always_comb begin
      in_legal = 1'b0;
      if (req_we) begin
         unique case (req_funct3)
            F3_B, F3_H, F3_W: in_legal = 1'b1;
            F3_D:             in_legal = (XLEN == 64);
            default:          in_legal = 1'b0;
         endcase
      end else begin
         unique case (req_funct3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: in_legal = 1'b1;
            F3_D, F3_WU:                    in_legal = (XLEN == 64);
            default:                        in_legal = 1'b0;
         endcase
      end
      in_end   = int'(req_addr[OFFW-1:0]) + int'(size_bytes(req_funct3));
      in_cross = (in_end > BYTES);
      in_fault = !in_legal || ((MISALIGN_SPLIT == 0) && in_cross);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Request field capture on acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         fault_q <= 1'b0;
      end else if (accept) begin
         we_q    <= req_we;
         f3_q    <= req_funct3;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         fault_q <= in_fault;
      end
   end

   // Load beat capture; a first beat also clears the upper half.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rbuf <= '0;
      end else if (mem_ready && !we_q) begin
         if (state == BEAT0)
            rbuf <= {{XLEN{1'b0}}, mem_rdata};
         else if (state == BEAT1)
            rbuf[2*XLEN-1:XLEN] <= mem_rdata;
      end
   end

   // Extract the addressed bytes and sign or zero extend.
   always_comb begin
      shifted  = rbuf >> {off_q, 3'b000};
      nb       = int'(size_bytes(f3_q));
      sgn      = !f3_q[2] && shifted[8*nb-1];
      load_res = '0;
      for (int i = 0; i < XLEN; i++)
         load_res[i] = (i < 8*nb) ? shifted[i] : sgn;
   end

   // Next state and output decode.
   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      mem_valid = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_be    = '0;
      mem_wdata = '0;
      rsp_valid = 1'b0;
      rsp_rdata = '0;
      rsp_fault = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nx = in_fault ? RESP : BEAT0;
         end
         BEAT0: begin
            mem_valid = 1'b1;
            mem_we    = we_q;
            mem_addr  = base_q;
            mem_be    = mask2[BYTES-1:0];
            if (we_q) mem_wdata = wdata2[XLEN-1:0];
            if (mem_ready) state_nx = split_q ? BEAT1 : RESP;
         end
         BEAT1: begin
            mem_valid = 1'b1;
            mem_we    = we_q;
            mem_addr  = base_q + ADDR_WIDTH'(BYTES);
            mem_be    = mask2[2*BYTES-1:BYTES];
            if (we_q) mem_wdata = wdata2[2*XLEN-1:XLEN];
            if (mem_ready) state_nx = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_fault = fault_q;
            if (!we_q && !fault_q) rsp_rdata = load_res;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule
